match_controller: RTL and testbench

MATCH_CONTROLLER -- requirements
Module: match_controller

---
 rtl/match_controller.sv | 145 ++++++++++++++
 tb/tb_match_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// Match controller for a two-player ball game. It runs the serve, rally,
// point-pause and match-over sequence and keeps both players' scores.
module match_controller #(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned POINT_DELAY = 60,
  parameter int unsigned GOAL_L      = 5,
  parameter int unsigned GOAL_R      = 795
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        tick,
  input  logic        serve,
  input  logic [10:0] ballLeft,
  input  logic [10:0] ballRight,
  output logic        ballRun,
  output logic        ballRecentre,
  output logic        serveDir,
  output logic [3:0]  scoreL,
  output logic [3:0]  scoreR,
  output logic [1:0]  winner,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [3:0]  WIN4    = 4'(WIN_SCORE);
  localparam logic [7:0]  DELAY8  = 8'(POINT_DELAY);
  localparam logic [10:0] GOAL_L11 = 11'(GOAL_L);
  localparam logic [10:0] GOAL_R11 = 11'(GOAL_R);

  state_t      r_state;
  logic        r_serve_q;
  logic [7:0]  r_cnt;
  logic        r_run;
  logic        r_recentre;
  logic        r_dir;
  logic [3:0]  r_score_l;
  logic [3:0]  r_score_r;
  logic [1:0]  r_winner;

  logic        w_serve_rise;
  logic        w_miss_l;
  logic        w_miss_r;
  logic [3:0]  w_score_l_inc;
  logic [3:0]  w_score_r_inc;

  assign w_serve_rise  = serve & ~r_serve_q;
  assign w_miss_l      = (ballLeft <= GOAL_L11);
  assign w_miss_r      = (ballRight >= GOAL_R11);
  assign w_score_l_inc = r_score_l + 4'd1;
  assign w_score_r_inc = r_score_r + 4'd1;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_serve_q  <= 1'b1;
      r_cnt      <= '0;
      r_run      <= 1'b0;
      r_recentre <= 1'b0;
      r_dir      <= 1'b0;
      r_score_l  <= '0;
      r_score_r  <= '0;
      r_winner   <= '0;
    end else begin
      r_serve_q  <= serve;
      r_recentre <= 1'b0;
      case (r_state)
        IDLE: begin
          r_run <= 1'b0;
          if (w_serve_rise) begin
            r_state    <= PLAY;
            r_run      <= 1'b1;
            r_recentre <= 1'b1;
          end
        end
        PLAY: begin
          r_run <= 1'b1;
          // Left miss has priority when both goal lines are crossed together.
          if (tick && w_miss_l) begin
            r_run     <= 1'b0;
            r_score_r <= w_score_r_inc;
            r_dir     <= 1'b0;
            if (w_score_r_inc == WIN4) begin
              r_state  <= OVER;
              r_winner <= 2'b10;
            end else begin
              r_state <= POINT;
              r_cnt   <= DELAY8;
            end
          end else if (tick && w_miss_r) begin
            r_run     <= 1'b0;
            r_score_l <= w_score_l_inc;
            r_dir     <= 1'b1;
            if (w_score_l_inc == WIN4) begin
              r_state  <= OVER;
              r_winner <= 2'b01;
            end else begin
              r_state <= POINT;
              r_cnt   <= DELAY8;
            end
          end
        end
        POINT: begin
          r_run <= 1'b0;
          if (tick) begin
            r_cnt <= r_cnt - 8'd1;
            if (r_cnt == 8'd1) begin
              r_state    <= PLAY;
              r_run      <= 1'b1;
              r_recentre <= 1'b1;
            end
          end
        end
        OVER: begin
          r_run <= 1'b0;
          if (w_serve_rise) begin
            r_state    <= IDLE;
            r_score_l  <= '0;
            r_score_r  <= '0;
            r_winner   <= '0;
            r_recentre <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_run   <= 1'b0;
        end
      endcase
    end
  end

  assign ballRun      = r_run;
  assign ballRecentre = r_recentre;
  assign serveDir     = r_dir;
  assign scoreL       = r_score_l;
  assign scoreR       = r_score_r;
  assign winner       = r_winner;
  assign state        = r_state;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: directed scenarios followed by random play,
// every cycle compared against a rule-level model of the match.
module tb_match_controller;

  localparam int WIN   = 7;
  localparam int DELAY = 60;
  localparam int GL    = 5;
  localparam int GR    = 795;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        tick  = 1'b0;
  logic        serve = 1'b0;
  logic [10:0] ballLeft  = 11'd400;
  logic [10:0] ballRight = 11'd410;
  logic        ballRun, ballRecentre, serveDir;
  logic [3:0]  scoreL, scoreR;
  logic [1:0]  winner;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  match_controller #(
    .WIN_SCORE  (WIN),
    .POINT_DELAY(DELAY),
    .GOAL_L     (GL),
    .GOAL_R     (GR)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .tick        (tick),
    .serve       (serve),
    .ballLeft    (ballLeft),
    .ballRight   (ballRight),
    .ballRun     (ballRun),
    .ballRecentre(ballRecentre),
    .serveDir    (serveDir),
    .scoreL      (scoreL),
    .scoreR      (scoreR),
    .winner      (winner),
    .state       (state)
  );

  always #5 Clock = ~Clock;

  // Reference model: phase numbers are the published state codes.
  int m_phase, m_sl, m_sr, m_win, m_pause;
  bit m_rec, m_dir, m_prev_serve;

  function automatic void model_edge(bit rst, bit t, bit s, int bl, int br);
    bit press;
    if (rst) begin
      m_phase = 0; m_sl = 0; m_sr = 0; m_win = 0; m_pause = 0;
      m_rec = 0; m_dir = 0; m_prev_serve = 1;
      return;
    end
    press = s && !m_prev_serve;
    m_prev_serve = s;
    m_rec = 0;
    if (m_phase == 0) begin
      if (press) begin m_phase = 2; m_rec = 1; end
    end else if (m_phase == 2) begin
      if (t && bl <= GL) begin
        m_sr = m_sr + 1; m_dir = 0;
        if (m_sr == WIN) begin m_phase = 4; m_win = 2; end
        else begin m_phase = 3; m_pause = DELAY; end
      end else if (t && br >= GR) begin
        m_sl = m_sl + 1; m_dir = 1;
        if (m_sl == WIN) begin m_phase = 4; m_win = 1; end
        else begin m_phase = 3; m_pause = DELAY; end
      end
    end else if (m_phase == 3) begin
      if (t) begin
        m_pause = m_pause - 1;
        if (m_pause == 0) begin m_phase = 2; m_rec = 1; end
      end
    end else if (m_phase == 4) begin
      if (press) begin
        m_phase = 0; m_sl = 0; m_sr = 0; m_win = 0; m_rec = 1;
      end
    end else begin
      m_phase = 0;
    end
  endfunction

  function automatic int model_vec();
    int v;
    v = (m_phase << 13) | (int'(m_phase == 2) << 12) | (int'(m_rec) << 11) |
        (int'(m_dir) << 10) | (m_sl << 6) | (m_sr << 2) | m_win;
    return v;
  endfunction

  function automatic int dut_vec();
    return int'({state, ballRun, ballRecentre, serveDir, scoreL, scoreR, winner});
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit t, input bit s, input int bl, input int br);
    @(negedge Clock);
    Reset = rst; tick = t; serve = s;
    ballLeft = 11'(bl); ballRight = 11'(br);
    @(posedge Clock);
    model_edge(rst, t, s, bl, br);
    #1;
    chk("cycle", dut_vec(), model_vec());
  endtask

  // Pause ticks with the ball parked mid-field, gaps between ticks.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, i[1], 400, 410);
      step(0, 1, i[1], 400, 410);
    end
  endtask

  task automatic start_match();
    step(1, 0, 0, 400, 410);
    step(0, 0, 0, 400, 410);
    step(0, 0, 1, 400, 410);
    step(0, 0, 0, 400, 410);
  endtask

  initial begin
    int bl, br, r;
    bit t, s, rst;

    // Reset state
    step(1, 0, 0, 400, 410);
    step(1, 0, 0, 400, 410);
    chk("rst_state", int'(state), 0);
    chk("rst_scores", int'({scoreL, scoreR, winner}), 0);
    chk("rst_run_rec_dir", int'({ballRun, ballRecentre, serveDir}), 0);

    // Serve start
    step(0, 0, 0, 400, 410);
    step(0, 0, 1, 400, 410);
    chk("serve_state", int'(state), 2);
    chk("serve_rec", int'(ballRecentre), 1);
    chk("serve_run", int'(ballRun), 1);
    step(0, 0, 1, 400, 410);
    chk("serve_rec_once", int'(ballRecentre), 0);

    // Left miss, then the point pause
    step(0, 1, 0, 5, 15);
    chk("lmiss_scoreR", int'(scoreR), 1);
    chk("lmiss_dir", int'(serveDir), 0);
    chk("lmiss_state", int'(state), 3);
    chk("lmiss_run", int'(ballRun), 0);
    ticks(59);
    chk("pause_59", int'(state), 3);
    step(0, 0, 0, 400, 410);
    step(0, 1, 0, 400, 410);
    chk("pause_end_rec", int'(ballRecentre), 1);
    chk("pause_end_state", int'(state), 2);

    // Right miss ignored without tick
    step(0, 0, 0, 785, 795);
    chk("rmiss_notick", int'({state, scoreL}), int'({3'd2, 4'd0}));
    step(0, 1, 0, 785, 795);
    chk("rmiss_scoreL", int'(scoreL), 1);
    chk("rmiss_dir", int'(serveDir), 1);
    ticks(60);

    // Both goal lines on one tick
    step(0, 1, 0, 0, 800);
    chk("both_scoreR", int'(scoreR), 2);
    chk("both_scoreL", int'(scoreL), 1);
    ticks(60);

    // Match end after seven right misses
    start_match();
    for (int k = 1; k <= WIN; k++) begin
      step(0, 1, 0, 785, 795);
      if (k < WIN) ticks(60);
    end
    chk("over_state", int'(state), 4);
    chk("over_winner", int'(winner), 1);
    chk("over_scoreL", int'(scoreL), 7);
    step(0, 1, 0, 0, 800);
    chk("over_tick_ignored", int'({scoreL, scoreR}), int'({4'd7, 4'd0}));
    step(0, 0, 1, 400, 410);
    chk("new_state", int'(state), 0);
    chk("new_scores", int'({scoreL, scoreR, winner}), 0);
    chk("new_rec", int'(ballRecentre), 1);

    // Reset mid-POINT with serve held high
    start_match();
    step(0, 1, 0, 3, 13);
    ticks(5);
    step(1, 1, 1, 400, 410);
    chk("midrst_vec", dut_vec(), 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 400, 410);
    chk("held_serve_idle", int'(state), 0);
    step(0, 0, 0, 400, 410);
    step(0, 0, 1, 400, 410);
    chk("repress_play", int'(state), 2);

    // Random play
    for (int i = 0; i < 8000; i++) begin
      r   = int'($urandom_range(0, 39));
      rst = ($urandom_range(0, 1999) == 0);
      t   = ($urandom_range(0, 2) == 0);
      s   = ($urandom_range(0, 15) == 0) ? !serve : serve;
      bl  = int'($urandom_range(100, 690));
      br  = bl + 10;
      if (r == 0) bl = int'($urandom_range(0, 6));
      if (r == 1) br = int'($urandom_range(794, 800));
      if (r == 2) begin bl = int'($urandom_range(0, 5)); br = int'($urandom_range(795, 800)); end
      step(rst, t, s, bl, br);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
